// File: rtl/io_display_ctrl_pkg.sv
// Shared constants and types for the board-I/O display peripheral.
package io_display_ctrl_pkg;

  localparam logic [15:0] IO_BASE_DEF = 16'hF000;
  localparam int unsigned WIN_LSB     = 5;  // 32-byte window: addr[4:0] is the offset

  // Word index (addr[4:2]) of each register
  localparam logic [2:0] REG_LEDR   = 3'd0;
  localparam logic [2:0] REG_LEDG   = 3'd1;
  localparam logic [2:0] REG_HEXVAL = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_TIMER  = 3'd4;

  // CTRL bit positions
  localparam int unsigned CTRL_DISP_EN  = 0;
  localparam int unsigned CTRL_BLINK_EN = 1;
  localparam int unsigned CTRL_MASK_LSB = 4;

  localparam int unsigned LEDR_W     = 10;
  localparam int unsigned LEDG_W     = 8;
  localparam int unsigned HEXVAL_W   = 16;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] blink_mask;
    logic       blink_en;
    logic       disp_en;
  } ctrl_t;

endpackage

// File: rtl/io_display_ctrl_if.sv
// Memory-stage access bus into the I/O window.
//  lock/wr_en/rd_en/addr/wr_data : driven by Memory
//  hit_c (comb), rd_data, rd_valid : returned by the peripheral
interface io_display_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              lock;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              hit_c;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output lock, wr_en, rd_en, addr, wr_data,
    input  hit_c, rd_data, rd_valid
  );

  modport slave (
    input  lock, wr_en, rd_en, addr, wr_data,
    output hit_c, rd_data, rd_valid
  );
endinterface

// File: rtl/io_display_ctrl_hex_to_7seg.sv
// Nibble to active-low seven-segment glyph (DE-board segment order).
//  nibble : 4-bit value
//  seg_c  : 7-bit active-low segments, combinational
module io_display_ctrl_hex_to_7seg
  import io_display_ctrl_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/io_display_ctrl.sv
// Memory-mapped board I/O: LEDR/LEDG/HEXVAL/CTRL registers, free-running
// readable timer, and HEX blink.
//  I_CLOCK, I_RESET : clock, async active-high reset
//  bus              : Memory-stage access bus (slave side)
//  O_LEDR, O_LEDG   : LED pins
//  O_HEX0..O_HEX3   : seven-seg digits, active-low, registered
module io_display_ctrl
  import io_display_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] IO_BASE   = IO_BASE_DEF,
  parameter int unsigned       TICK_DIV  = 32'd50,
  parameter int unsigned       BLINK_DIV = 32'd1000
)(
  input  logic               I_CLOCK,
  input  logic               I_RESET,
  io_display_ctrl_if.slave   bus,
  output logic [LEDR_W-1:0]  O_LEDR,
  output logic [LEDG_W-1:0]  O_LEDG,
  output logic [SEG_W-1:0]   O_HEX0,
  output logic [SEG_W-1:0]   O_HEX1,
  output logic [SEG_W-1:0]   O_HEX2,
  output logic [SEG_W-1:0]   O_HEX3
);

  localparam int unsigned PRESC_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [LEDR_W-1:0]   ledr;
  logic [LEDG_W-1:0]   ledg;
  logic [HEXVAL_W-1:0] hexval;
  ctrl_t               ctrl;
  logic [DATA_W-1:0]   timer;
  logic [PRESC_W-1:0]  presc;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                phase;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_mux_c;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_c;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_q;
  logic [NUM_DIGITS-1:0]            blank_c;
  logic [2:0]          reg_idx;
  logic                wr_go;
  logic                rd_go;
  logic                unused_addr_lsb;

  // Address decode: byte offset bits [1:0] are don't-care
  assign bus.hit_c       = (bus.addr[ADDR_W-1:WIN_LSB] == IO_BASE[ADDR_W-1:WIN_LSB]);
  assign reg_idx         = bus.addr[4:2];
  assign wr_go           = bus.lock && bus.wr_en && bus.hit_c;
  assign rd_go           = bus.lock && bus.rd_en && bus.hit_c;
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Read mux over pre-write register contents
  always_comb begin
    rd_mux_c = '0;
    case (reg_idx)
      REG_LEDR:   rd_mux_c = DATA_W'(ledr);
      REG_LEDG:   rd_mux_c = DATA_W'(ledg);
      REG_HEXVAL: rd_mux_c = DATA_W'(hexval);
      REG_CTRL:   rd_mux_c = DATA_W'({ctrl.blink_mask, 2'b00, ctrl.blink_en, ctrl.disp_en});
      REG_TIMER:  rd_mux_c = timer;
      default:    rd_mux_c = '0;
    endcase
  end

  // Register bank
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      ledr   <= '0;
      ledg   <= '0;
      hexval <= '0;
      ctrl   <= '0;
    end else if (wr_go) begin
      case (reg_idx)
        REG_LEDR:   ledr   <= bus.wr_data[LEDR_W-1:0];
        REG_LEDG:   ledg   <= bus.wr_data[LEDG_W-1:0];
        REG_HEXVAL: hexval <= bus.wr_data[HEXVAL_W-1:0];
        REG_CTRL: begin
          ctrl.disp_en    <= bus.wr_data[CTRL_DISP_EN];
          ctrl.blink_en   <= bus.wr_data[CTRL_BLINK_EN];
          ctrl.blink_mask <= bus.wr_data[CTRL_MASK_LSB +: 4];
        end
        default: ;
      endcase
    end
  end

  // Read return, latency 1; data holds between reads
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) rd_data_q <= rd_mux_c;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  // Timer: a TIMER write clears both counters, even on the prescaler wrap cycle
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      presc <= '0;
      timer <= '0;
    end else if (wr_go && (reg_idx == REG_TIMER)) begin
      presc <= '0;
      timer <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      timer <= timer + DATA_W'(1);
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Blink phase, free-running
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Per-digit glyph decode and blanking
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    io_display_ctrl_hex_to_7seg u_seg (
      .nibble (hexval[4*i +: 4]),
      .seg_c  (seg_c[i])
    );
    assign blank_c[i] = !ctrl.disp_en || (ctrl.blink_en && ctrl.blink_mask[i] && phase);
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      hex_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_q[i] <= blank_c[i] ? SEG_BLANK : seg_c[i];
      end
    end
  end

  assign O_LEDR = ledr;
  assign O_LEDG = ledg;
  assign O_HEX0 = hex_q[0];
  assign O_HEX1 = hex_q[1];
  assign O_HEX2 = hex_q[2];
  assign O_HEX3 = hex_q[3];

endmodule

// File: tb/tb_io_display_ctrl.sv
// Directed bench for io_display_ctrl with a read-data scoreboard.
module tb_io_display_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_display_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  io_display_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  logic [9:0] ledr_a, ledr_b;
  logic [7:0] ledg_a, ledg_b;
  logic [6:0] hex0_a, hex1_a, hex2_a, hex3_a;
  logic [6:0] hex0_b, hex1_b, hex2_b, hex3_b;

  io_display_ctrl #(.TICK_DIV(4), .BLINK_DIV(8)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .bus(bus_a),
    .O_LEDR(ledr_a), .O_LEDG(ledg_a),
    .O_HEX0(hex0_a), .O_HEX1(hex1_a), .O_HEX2(hex2_a), .O_HEX3(hex3_a)
  );

  // Second instance with a 1-clock tick so the 16-bit wrap is reachable
  io_display_ctrl #(.TICK_DIV(1), .BLINK_DIV(8)) dut_wrap (
    .I_CLOCK(clk), .I_RESET(rst), .bus(bus_b),
    .O_LEDR(ledr_b), .O_LEDG(ledg_b),
    .O_HEX0(hex0_b), .O_HEX1(hex1_b), .O_HEX2(hex2_b), .O_HEX3(hex3_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [6:0]  s[40];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bus_a.addr = a; bus_a.wr_data = d; bus_a.wr_en = 1'b1;
    step();
    bus_a.wr_en = 1'b0;
  endtask

  // Wait (bounded) for rd_valid, compare against the scoreboard head, then check the pulse drops
  task automatic wait_rd(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      if (bus_a.rd_valid === 1'b1) begin
        got = 1'b1;
        check(tag, bus_a.rd_data, exp_q.pop_front());
      end else begin
        step();
      end
    end
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL %s_timeout observed=no_rd_valid expected=rd_valid", tag);
      exp_q.delete();
    end
    if (got) begin
      step();
      check({tag, "_drop"}, 16'(bus_a.rd_valid), 16'h0);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
    exp_q.push_back(exp);
    bus_a.addr = a; bus_a.rd_en = 1'b1;
    step();
    bus_a.rd_en = 1'b0;
    wait_rd(tag);
  endtask

  task automatic no_read(input logic [15:0] a, input logic [15:0] held, input string tag);
    bus_a.addr = a; bus_a.rd_en = 1'b1;
    step();
    bus_a.rd_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check(tag, 16'(bus_a.rd_valid), 16'h0);
      step();
    end
    check({tag, "_hold"}, bus_a.rd_data, held);
  endtask

  initial begin
    int j;
    logic [6:0] g;
    rst = 1'b1;
    bus_a.lock = 1'b1; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    bus_a.addr = '0; bus_a.wr_data = '0;
    bus_b.lock = 1'b1; bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
    bus_b.addr = '0; bus_b.wr_data = '0;
    @(negedge clk);
    check("rst_ledr", 16'(ledr_a), 16'h0);
    check("rst_hex0", 16'(hex0_a), 16'h7F);
    check("rst_rdvalid", 16'(bus_a.rd_valid), 16'h0);
    check("rst_rddata", bus_a.rd_data, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Window decode
    bus_a.addr = 16'hF01C; #1 check("hit_top", 16'(bus_a.hit_c), 16'h1);
    bus_a.addr = 16'hF020; #1 check("hit_above", 16'(bus_a.hit_c), 16'h0);
    bus_a.addr = 16'hEFFF; #1 check("hit_below", 16'(bus_a.hit_c), 16'h0);
    @(negedge clk);

    // Writes, upper bits dropped
    do_write(16'hF000, 16'hFFFF);
    do_write(16'hF004, 16'h01A5);
    do_write(16'hF008, 16'h1A2F);
    check("hex_before_en", 16'(hex0_a), 16'h7F);
    do_write(16'hF00C, 16'h0001);
    step(); step();
    check("ledr", 16'(ledr_a), 16'h03FF);
    check("ledg", 16'(ledg_a), 16'h00A5);
    check("hex3", 16'(hex3_a), 16'h79);
    check("hex2", 16'(hex2_a), 16'h08);
    check("hex1", 16'(hex1_a), 16'h24);
    check("hex0", 16'(hex0_a), 16'h0E);

    // Reads
    do_read(16'hF008, 16'h1A2F, "rd_hexval");
    do_read(16'hF018, 16'h0000, "rd_unmapped");
    do_read(16'hF003, 16'h03FF, "rd_ledr_lsb");
    no_read(16'h1000, 16'h03FF, "rd_nohit");
    do_read(16'hF00C, 16'h0001, "rd_ctrl");
    do_write(16'hF00C, 16'hFFFF);
    do_read(16'hF00C, 16'h00F3, "rd_ctrl_bits");
    do_write(16'hF00C, 16'h0001);
    do_write(16'hF014, 16'hBEEF);
    do_read(16'hF014, 16'h0000, "rd_unmapped_wr");

    // Lock low: access ignored
    bus_a.lock = 1'b0;
    do_write(16'hF004, 16'h0011);
    step();
    check("lock_wr", 16'(ledg_a), 16'h00A5);
    no_read(16'hF004, 16'h0000, "lock_rd");
    bus_a.lock = 1'b1;

    // Same-cycle read and write: old value returned
    exp_q.push_back(16'h00A5);
    bus_a.addr = 16'hF004; bus_a.wr_data = 16'h003C;
    bus_a.wr_en = 1'b1; bus_a.rd_en = 1'b1;
    step();
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    wait_rd("rdwr_old");
    check("rdwr_new", 16'(ledg_a), 16'h003C);
    do_read(16'hF004, 16'h003C, "rd_ledg_new");

    // Timer, TICK_DIV=4
    do_write(16'hF010, 16'h1234);
    repeat (40) step();
    do_read(16'hF010, 16'd10, "timer_40");
    do_write(16'hF010, 16'h0);
    repeat (39) step();
    do_read(16'hF010, 16'd9, "timer_39");
    do_write(16'hF010, 16'h0);
    do_read(16'hF010, 16'd0, "timer_clear");
    do_write(16'hF010, 16'h0);
    repeat (3) step();
    do_write(16'hF010, 16'h0);          // lands on the prescaler wrap edge
    do_read(16'hF010, 16'd0, "timer_clear_wins");

    // Blink, BLINK_DIV=8, digit 0 only
    do_write(16'hF00C, 16'h0013);
    step(); step();
    for (int i = 0; i < 40; i++) begin
      s[i] = hex0_a;
      check("blink_hex1", 16'(hex1_a), 16'h24);
      step();
    end
    j = 0;
    for (int i = 1; i < 10; i++) if (j == 0 && s[i] !== s[i-1]) j = i;
    checks++;
    assert (j != 0) else begin
      failures++;
      $error("FAIL blink_toggle observed=no_change expected=change_within_9");
    end
    if (j != 0) begin
      g = (s[j] === 7'h7F) ? s[j-1] : s[j];
      check("blink_glyph", 16'(g), 16'h0E);
      check("blink_has_blank", 16'((s[j] === 7'h7F) || (s[j-1] === 7'h7F)), 16'h1);
      for (int i = j; i < j + 24; i++)
        check("blink_period", 16'(s[i]), 16'((((i - j) / 8) % 2 == 0) ? s[j] : s[j-1]));
    end
    check("blink_hex3", 16'(hex3_a), 16'h79);
    do_write(16'hF00C, 16'h0000);
    step(); step();
    check("disp_off_hex0", 16'(hex0_a), 16'h7F);
    check("disp_off_hex2", 16'(hex2_a), 16'h7F);

    // Reset during a pending read response
    bus_a.addr = 16'hF000; bus_a.rd_en = 1'b1;
    step();
    bus_a.rd_en = 1'b0;
    check("pre_rst_valid", 16'(bus_a.rd_valid), 16'h1);
    check("pre_rst_data", bus_a.rd_data, 16'h03FF);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 16'(bus_a.rd_valid), 16'h0);
    check("mid_rst_data", bus_a.rd_data, 16'h0);
    check("mid_rst_ledr", 16'(ledr_a), 16'h0);
    check("mid_rst_ledg", 16'(ledg_a), 16'h0);
    check("mid_rst_hex1", 16'(hex1_a), 16'h7F);
    @(negedge clk);
    rst = 1'b0;
    step();
    do_read(16'hF008, 16'h0000, "post_rst_hexval");

    // 16-bit timer wrap on the TICK_DIV=1 instance
    bus_b.addr = 16'hF010; bus_b.wr_en = 1'b1;
    step();
    bus_b.wr_en = 1'b0;
    repeat (65535) step();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    bus_b.rd_en = 1'b1;
    step();
    check("wrap_valid_a", 16'(bus_b.rd_valid), 16'h1);
    check("wrap_ffff", bus_b.rd_data, exp_q.pop_front());
    step();
    bus_b.rd_en = 1'b0;
    check("wrap_valid_b", 16'(bus_b.rd_valid), 16'h1);
    check("wrap_zero", bus_b.rd_data, exp_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
